// File: rtl/uart_tx_fifo.sv
// Byte-serialising 8N1 UART transmitter fed by the core's uart_out strobe.
// A FIFO absorbs bursts; a START/DATA/STOP sequencer drains it with no gap between frames.
module uart_tx_fifo #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [8:0]                    uart_in,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_bit;
   logic [7:0]         r_shift;
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               r_overflow;
   logic               r_tx;
   logic               r_busy;

   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [2:0]         w_bit_nxt;
   logic [7:0]         w_shift_nxt;
   logic               w_pop;
   logic               w_baud_end;
   logic               w_fifo_nonempty;
   logic [7:0]         w_head;
   logic               w_push;
   logic               w_push_ok;
   logic [CW-1:0]      w_count_nxt;
   logic               w_tx_nxt;
   logic               w_busy_nxt;

   assign w_baud_end      = (r_cnt == CNT_W'(CLK_DIV - 1));
   assign w_fifo_nonempty = (r_count != '0);
   assign w_head          = r_mem[r_rd_ptr];
   assign w_push          = uart_in[8];

   // State register plus FIFO bookkeeping; reset wins over any push on the same edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit      <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_count    <= w_count_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_push_ok) r_overflow <= 1'b1;
      end
   end

   // Storage array carries no reset; pointers alone define its contents.
   always_ff @(posedge clock) begin
      if (reset_n && w_push_ok) r_mem[r_wr_ptr] <= uart_in[7:0];
   end

   // Next-state logic: baud counter reloads on every state or bit transition.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_fifo_nonempty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_baud_end) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_cnt_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               w_cnt_nxt = '0;
               if (w_fifo_nonempty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so tx and busy land in registers.
   always_comb begin
      w_tx_nxt    = 1'b1;
      w_push_ok   = w_push && ((r_count != CW'(FIFO_DEPTH)) || w_pop);
      w_count_nxt = r_count;
      unique case ({w_push_ok, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
      unique case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
   end

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a frame-timing reference model.
module tb_uart_tx_fifo;

   localparam int unsigned CD    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int          FRAME = 10 * CD;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [8:0] uart_in;
   logic       tx;
   logic       busy;
   logic [4:0] fifo_count;
   logic       overflow;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   uart_tx_fifo #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .uart_in    (uart_in),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a byte queue plus elapsed time within the current frame.
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_elapsed = 0;
   logic [7:0] m_cur = 8'h00;
   bit         m_ovf = 1'b0;
   bit         m_pop;
   int         m_before;

   always @(posedge clock) begin
      if (!reset_n) begin
         m_q.delete();
         m_active  = 1'b0;
         m_elapsed = 0;
         m_ovf     = 1'b0;
      end else begin
         m_pop    = 1'b0;
         m_before = m_q.size();
         if (m_active) begin
            if (m_elapsed == FRAME - 1) begin
               if (m_before > 0) m_pop = 1'b1;
               else m_active = 1'b0;
               m_elapsed = 0;
            end else begin
               m_elapsed++;
            end
         end else if (m_before > 0) begin
            m_pop = 1'b1;
         end
         if (uart_in[8]) begin
            if (m_before < int'(DEPTH) || m_pop) m_q.push_back(uart_in[7:0]);
            else m_ovf = 1'b1;
         end
         if (m_pop) begin
            m_cur     = m_q.pop_front();
            m_active  = 1'b1;
            m_elapsed = 0;
         end
      end
   end

   function automatic logic exp_tx();
      int pos;
      if (!m_active) return 1'b1;
      pos = m_elapsed / int'(CD);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return m_cur[pos-1];
      return 1'b1;
   endfunction

   always @(negedge clock) begin
      if (chk_on) begin
         check_eq("tx", 32'(tx), 32'(exp_tx()));
         check_eq("busy", 32'(busy), 32'(m_active || (m_q.size() != 0)));
         check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
         check_eq("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic drive(input bit stb, input logic [7:0] b);
      uart_in = {stb, b};
      @(negedge clock);
      uart_in = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((m_active || m_q.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      check_eq("drain_busy", 32'(busy), 32'(0));
   endtask

   task automatic wait_elapsed(input int target, input int budget);
      int n = 0;
      while (!(m_active && m_elapsed == target) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_eq("wait_phase", 32'(m_elapsed), 32'(target));
   endtask

   logic [7:0] pat;
   int         rate;
   logic [7:0] nxt;

   initial begin
      reset_n = 1'b0;
      uart_in = '0;
      idle(2);
      // Strobe coincident with reset must be discarded.
      uart_in = {1'b1, 8'h99};
      @(negedge clock);
      uart_in = '0;
      reset_n = 1'b1;
      chk_on  = 1'b1;
      check_eq("rst_tx", 32'(tx), 32'(1));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_count", 32'(fifo_count), 32'(0));
      check_eq("rst_ovf", 32'(overflow), 32'(0));
      idle(3);

      // Single 0x55 frame: explicit bit pattern.
      pat = 8'h55;
      drive(1'b1, pat);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clock);
         if (k < int'(CD))            check_eq("t1_start", 32'(tx), 32'(0));
         else if (k < 9 * int'(CD))   check_eq("t1_data", 32'(tx), 32'(pat[(k - int'(CD)) / int'(CD)]));
         else                         check_eq("t1_stop", 32'(tx), 32'(1));
      end
      @(negedge clock);
      check_eq("t1_busy_end", 32'(busy), 32'(0));
      check_eq("t1_ovf", 32'(overflow), 32'(0));
      idle(5);

      // Burst of three consecutive pushes.
      drive(1'b1, 8'h41);
      check_eq("burst_c0", 32'(fifo_count), 32'(1));
      drive(1'b1, 8'h42);
      check_eq("burst_c1", 32'(fifo_count), 32'(1));
      drive(1'b1, 8'h43);
      check_eq("burst_c2", 32'(fifo_count), 32'(2));
      wait_drain(200);

      // Overflow: bytes 0..17 on consecutive edges, byte 17 dropped.
      for (int i = 0; i < 18; i++) drive(1'b1, 8'(i));
      check_eq("ovf_set", 32'(overflow), 32'(1));
      check_eq("ovf_count", 32'(fifo_count), 32'(DEPTH));
      wait_drain(1200);
      check_eq("ovf_sticky", 32'(overflow), 32'(1));

      // Full FIFO with push on the STOP->START pop edge.
      do_reset();
      for (int i = 0; i < 17; i++) drive(1'b1, 8'($urandom_range(0, 255)));
      wait_elapsed(FRAME - 1, 100);
      check_eq("full_pre", 32'(fifo_count), 32'(DEPTH));
      drive(1'b1, 8'($urandom_range(0, 255)));
      check_eq("full_post", 32'(fifo_count), 32'(DEPTH));
      check_eq("full_ovf", 32'(overflow), 32'(0));
      wait_drain(1200);

      // Reset mid-frame during data bit 3 with five bytes queued.
      for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom_range(0, 255)));
      wait_elapsed(4 * int'(CD) + 1, 100);
      check_eq("mid_queued", 32'(fifo_count), 32'(5));
      do_reset();
      check_eq("mid_tx", 32'(tx), 32'(1));
      check_eq("mid_count", 32'(fifo_count), 32'(0));
      check_eq("mid_busy", 32'(busy), 32'(0));
      check_eq("mid_ovf", 32'(overflow), 32'(0));
      drive(1'b1, 8'hA5);
      wait_drain(100);

      // Pointer wrap: 40 bytes in groups of seven.
      nxt = 8'h00;
      while (nxt < 8'h28) begin
         for (int j = 0; j < 7 && nxt < 8'h28; j++) begin
            drive(1'b1, nxt);
            nxt = nxt + 8'd1;
         end
         wait_drain(400);
      end

      // Random traffic with varying push rate and rare resets.
      for (int blk = 0; blk < 10; blk++) begin
         rate = ($urandom_range(0, 1) == 0) ? 3 : 45;
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 599) == 0) begin
               reset_n = 1'b0;
               drive(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)));
               reset_n = 1'b1;
            end else begin
               drive(($urandom_range(0, rate - 1) == 0), 8'($urandom_range(0, 255)));
            end
         end
      end
      wait_drain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
